// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit with architectural HI/LO registers.
// Optional divider enabled by defining MDU_DIV_EN; default build treats div/divu as no-ops.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [3:0] LP_MCNT = 4'(MULT_CYCLES);

  logic [3:0]  r_cnt;
  logic [31:0] r_res_hi;
  logic [31:0] r_res_lo;
  logic        r_wr;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [3:0]  w_cnt;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_wr;
  logic [31:0] w_hi;
  logic [31:0] w_lo;

  logic        w_idle;
  logic        w_last;
  logic        w_accept;

  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;

  assign w_idle   = (r_cnt == 4'd0);
  assign w_last   = (r_cnt == 4'd1);
  // A new mult/div may be sampled on the edge where the running one retires.
  assign w_accept = start && (w_idle || w_last);

  assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'd0, A} * {32'd0, B};

`ifdef MDU_DIV_EN
  localparam logic [3:0] LP_DCNT = 4'(DIV_CYCLES);

  logic        w_b_nz;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;

  // Signed division is done on magnitudes so the most-negative / -1 case
  // wraps naturally to 0x80000000 with a zero remainder.
  assign w_b_nz  = (B != 32'd0);
  assign w_a_mag = A[31] ? (~A + 32'd1) : A;
  assign w_b_mag = B[31] ? (~B + 32'd1) : B;
  assign w_q_mag = w_b_nz ? (w_a_mag / w_b_mag) : 32'd0;
  assign w_r_mag = w_b_nz ? (w_a_mag % w_b_mag) : 32'd0;
  assign w_q_s   = (A[31] ^ B[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_r_s   = A[31] ? (~w_r_mag + 32'd1) : w_r_mag;
  assign w_q_u   = w_b_nz ? (A / B) : 32'd0;
  assign w_r_u   = w_b_nz ? (A % B) : 32'd0;
`else
  logic w_unused_div;
  assign w_unused_div = ^{4'(DIV_CYCLES)};
`endif

  // Next-state: counter, pending result, and HI/LO write-back.
  always_comb begin
    w_cnt    = w_idle ? 4'd0 : (r_cnt - 4'd1);
    w_res_hi = r_res_hi;
    w_res_lo = r_res_lo;
    w_wr     = r_wr;
    w_hi     = r_hi;
    w_lo     = r_lo;
    if (w_last && r_wr) begin
      w_hi = r_res_hi;
      w_lo = r_res_lo;
    end
    if (w_accept) begin
      case (op)
        OP_MULT: begin
          w_cnt    = LP_MCNT;
          w_res_hi = w_prod_s[63:32];
          w_res_lo = w_prod_s[31:0];
          w_wr     = 1'b1;
        end
        OP_MULTU: begin
          w_cnt    = LP_MCNT;
          w_res_hi = w_prod_u[63:32];
          w_res_lo = w_prod_u[31:0];
          w_wr     = 1'b1;
        end
`ifdef MDU_DIV_EN
        OP_DIV: begin
          w_cnt    = LP_DCNT;
          w_res_hi = w_r_s;
          w_res_lo = w_q_s;
          w_wr     = w_b_nz;
        end
        OP_DIVU: begin
          w_cnt    = LP_DCNT;
          w_res_hi = w_r_u;
          w_res_lo = w_q_u;
          w_wr     = w_b_nz;
        end
`endif
        OP_MTHI: begin
          if (w_idle) w_hi = A;
        end
        OP_MTLO: begin
          if (w_idle) w_lo = A;
        end
        default: begin
        end
      endcase
    end
  end

  // State registers; reset aborts any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= 4'd0;
      r_res_hi <= 32'd0;
      r_res_lo <= 32'd0;
      r_wr     <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      r_cnt    <= w_cnt;
      r_res_hi <= w_res_hi;
      r_res_lo <= w_res_lo;
      r_wr     <= w_wr;
      r_hi     <= w_hi;
      r_lo     <= w_lo;
    end
  end

  assign busy = ~w_idle;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vectors for md_unit, checked every cycle against
// a transaction-level HI/LO model plus hand-computed literal expectations.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int vectors;
  int miscompares;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: an operation accepted at edge k lands at edge k+N.
  longint      cyc;
  longint      done_at;
  bit          pend_wr;
  logic [31:0] p_hi, p_lo;
  logic [31:0] m_hi, m_lo;
  bit          chk_en;

  function automatic bit div_enabled();
`ifdef MDU_DIV_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      done_at = 0;
      pend_wr = 0;
      m_hi = 0;
      m_lo = 0;
      if (clk) cyc = cyc + 1;
    end else begin
      longint sa, sb;
      cyc = cyc + 1;
      if (done_at == cyc && pend_wr) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
      if (start) begin
        sa = longint'($signed(A));
        sb = longint'($signed(B));
        if (done_at <= cyc && (op == 3'd0 || op == 3'd1)) begin
          longint pr;
          if (op == 3'd0) pr = sa * sb;
          else pr = longint'({32'd0, A}) * longint'({32'd0, B});
          p_hi = pr[63:32];
          p_lo = pr[31:0];
          pend_wr = 1;
          done_at = cyc + MC;
        end else if (done_at <= cyc && div_enabled() &&
                     (op == 3'd2 || op == 3'd3)) begin
          longint x, y;
          if (op == 3'd2) begin
            x = sa;
            y = sb;
          end else begin
            x = longint'({32'd0, A});
            y = longint'({32'd0, B});
          end
          pend_wr = (y != 0);
          if (y != 0) begin
            longint q, r;
            q = x / y;
            r = x % y;
            p_lo = q[31:0];
            p_hi = r[31:0];
          end
          done_at = cyc + DC;
        end else if (done_at < cyc && op == 3'd4) begin
          m_hi = A;
        end else if (done_at < cyc && op == 3'd5) begin
          m_lo = A;
        end
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit eb;
      eb = (done_at > cyc);
      vectors++;
      if (busy !== eb || HI !== m_hi || LO !== m_lo) begin
        miscompares++;
        $display("FAIL cycle %0d: busy=%b HI=%h LO=%h, model busy=%b HI=%h LO=%h",
                 cyc, busy, HI, LO, eb, m_hi, m_lo);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op and count the busy cycles that follow (bounded).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int nb);
    @(negedge clk);
    start = 1'b1;
    op = o;
    A = a;
    B = b;
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      nb++;
      @(negedge clk);
    end
    if (busy) begin
      miscompares++;
      $display("FAIL timeout: busy still %b after 40 cycles", busy);
    end
  endtask

  int nb;

  initial begin
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    done_at = 0;
    pend_wr = 0;
    p_hi = 0;
    p_lo = 0;
    m_hi = 0;
    m_lo = 0;
    chk_en = 0;
    start = 0;
    op = 0;
    A = 0;
    B = 0;
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    chk_en = 1;
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset HI", HI, 32'd0);
    check("reset LO", LO, 32'd0);

    run_op(3'd0, 32'hFFFFFFFF, 32'h2, nb);
    check("mult busy cycles", 32'(nb), 32'd5);
    check("mult HI", HI, 32'hFFFFFFFF);
    check("mult LO", LO, 32'hFFFFFFFE);

    run_op(3'd1, 32'hFFFFFFFF, 32'h2, nb);
    check("multu busy cycles", 32'(nb), 32'd5);
    check("multu HI", HI, 32'h00000001);
    check("multu LO", LO, 32'hFFFFFFFE);

    run_op(3'd4, 32'h11, 32'h0, nb);
    run_op(3'd5, 32'h22, 32'h0, nb);
    if (div_enabled()) begin
      run_op(3'd2, 32'hFFFFFFF9, 32'h2, nb);
      check("div busy cycles", 32'(nb), 32'd10);
      check("div LO", LO, 32'hFFFFFFFD);
      check("div HI", HI, 32'hFFFFFFFF);
      run_op(3'd3, 32'd100, 32'd7, nb);
      check("divu LO", LO, 32'd14);
      check("divu HI", HI, 32'd2);
      run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, nb);
      check("div ovf LO", LO, 32'h80000000);
      check("div ovf HI", HI, 32'h0);
      run_op(3'd4, 32'h11, 32'h0, nb);
      run_op(3'd5, 32'h22, 32'h0, nb);
      run_op(3'd3, 32'd5, 32'd0, nb);
      check("div0 busy cycles", 32'(nb), 32'd10);
    end else begin
      run_op(3'd2, 32'hFFFFFFF9, 32'h2, nb);
      check("div off busy cycles", 32'(nb), 32'd0);
      run_op(3'd3, 32'd100, 32'd7, nb);
      check("divu off busy cycles", 32'(nb), 32'd0);
    end
    check("hold HI", HI, 32'h11);
    check("hold LO", LO, 32'h22);

    run_op(3'd6, 32'h1234, 32'h5678, nb);
    check("nop busy cycles", 32'(nb), 32'd0);
    check("nop HI", HI, 32'h11);

    run_op(3'd4, 32'hDEADBEEF, 32'h0, nb);
    check("mthi busy cycles", 32'(nb), 32'd0);
    check("mthi HI", HI, 32'hDEADBEEF);

    // mtlo during a mult run must be ignored.
    @(negedge clk);
    start = 1;
    op = 3'd0;
    A = 32'd3;
    B = 32'd4;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    start = 1;
    op = 3'd5;
    A = 32'h55;
    @(negedge clk);
    start = 0;
    repeat (6) @(negedge clk);
    check("mtlo in run LO", LO, 32'd12);
    check("mtlo in run HI", HI, 32'd0);

    // Back-to-back mult accepted on the completion edge.
    @(negedge clk);
    start = 1;
    op = 3'd1;
    A = 32'd6;
    B = 32'd7;
    @(negedge clk);
    start = 0;
    repeat (MC - 1) @(negedge clk);
    start = 1;
    A = 32'd9;
    B = 32'd10;
    @(negedge clk);
    start = 0;
    check("b2b first LO", LO, 32'd42);
    check("b2b still busy", 32'(busy), 32'd1);
    repeat (MC) @(negedge clk);
    check("b2b second LO", LO, 32'd90);
    check("b2b idle", 32'(busy), 32'd0);

    // Reset in cycle 4 of a multi-cycle op.
    @(negedge clk);
    start = 1;
    op = div_enabled() ? 3'd3 : 3'd0;
    A = 32'd100;
    B = 32'd7;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1;
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst HI", HI, 32'd0);
    check("rst LO", LO, 32'd0);
    @(negedge clk);
    reset = 0;
    repeat (DC + 2) @(negedge clk);
    check("post rst HI", HI, 32'd0);
    check("post rst LO", LO, 32'd0);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit in the EX stage of the five-stage pipeline, alongside the ALU. It takes the forwarded RS/RT operands from the EX-stage forwarding muxes and executes mult, multu, div, divu, mthi and mtlo. Results go into architectural HI/LO registers, which mfhi/mflo read. The hazard controller uses `busy` to stall ID while a multi-cycle operation is in flight.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: cycles `busy` stays high for mult/multu; legal range 1..15.
- `DIV_CYCLES`, default 10: cycles `busy` stays high for div/divu; legal range 1..15.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: qualifies `op`, `A` and `B` for one cycle. The EX stage drives it only for a valid, non-flushed MD instruction.
- `op` input 3: operation select.
  - 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo.
  - 110 and 111 are no-ops.
- `A` input 32: RS operand, already forwarded.
- `B` input 32: RT operand, already forwarded.
- `busy` output 1: high while a mult or div is in progress.
- `HI` output 32: HI register contents.
- `LO` output 32: LO register contents.

## Operation
- States:
  - IDLE: counter == 0.
  - RUN: counter != 0.
  - `busy` = (counter != 0), decoded directly from a registered 4-bit counter.
- IDLE, `start` with mult/multu:
  - Latch the full 64-bit product into internal registers.
  - Load the counter with `MULT_CYCLES`.
  - Signed product for mult, unsigned for multu.
- IDLE, `start` with div/divu:
  - Latch quotient and remainder; load the counter with `DIV_CYCLES`.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
- Divide by zero (B == 0): HI/LO are left unchanged at completion. The counter still runs the full `DIV_CYCLES`.
- RUN: the counter decrements each edge.
  - On the 1→0 edge, HI ← upper product or remainder, LO ← lower product or quotient.
- mthi/mtlo, IDLE only: HI (resp. LO) ← A on the sampling edge. `busy` stays 0.
- `start` while RUN: ignored for every op, including mthi/mtlo. The controller must stall rather than rely on this.
- `start` with op 110/111: no state change.
- HI/LO are never exposed before completion. During RUN they hold their previous values.

## Timing
- Reset values: `busy`=0, `HI`=0, `LO`=0, counter=0, internal result registers=0.
- Reset mid-operation clears everything asynchronously; no later HI/LO update occurs.
- Edge E0 samples `start` with a mult:
  - `busy` is high for the cycles after E0 through the cycle before E0+`MULT_CYCLES`.
  - `busy` is high for exactly `MULT_CYCLES` cycles.
  - HI/LO take the new value at edge E0+`MULT_CYCLES`, the same edge on which `busy` falls.
- Div follows the same rule with `DIV_CYCLES`.
- A new `start` is accepted on the edge where `busy` falls: the counter reloads and HI/LO still take the completing result.
  - The new operation's result overwrites HI/LO later.
- mthi/mtlo: zero-cycle latency to the register; visible on `HI`/`LO` in the cycle after the sampling edge.
- `HI`, `LO` and `busy` are register outputs, with no combinational path from the inputs.

## Configuration
- `MDU_DIV_EN` defined:
  - div/divu are implemented as above.
- `MDU_DIV_EN` undefined:
  - The divider logic is removed and op 010/011 behaves as a no-op: no `busy`, HI/LO unchanged.
  - `DIV_CYCLES` is ignored.
  - mult/multu/mthi/mtlo are unaffected.

## Test plan
- mult, A=0xFFFFFFFF, B=0x00000002 → `busy` high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu, same operands → HI=0x00000001, LO=0xFFFFFFFE after 5 cycles; HI/LO unchanged during RUN.
- div, A=0xFFFFFFF9 (−7), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu, A=100, B=7 → LO=14, HI=2.
- divu, A=5, B=0, with HI=0x11, LO=0x22 beforehand → `busy` high 10 cycles, then HI=0x11, LO=0x22.
- mthi A=0xDEADBEEF in IDLE → HI=0xDEADBEEF the next cycle, `busy` never rises.
  - mtlo issued during a mult RUN is ignored; LO ends at the product.
- reset pulse at cycle 4 of a div → `busy`, HI and LO are 0 immediately and stay 0.
  - Back-to-back mult accepted on the completion edge → both results land at the correct edges.
